// File: rtl/aes_ks_pkg.sv
// aes_ks_pkg: shared constants, FSM encoding and word helpers for the
// AES-128 key-schedule stage.
package aes_ks_pkg;

  localparam int NR   = 10;
  localparam int RK_W = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREP   = 2'd1,
    STREAM = 2'd2
  } ks_state_e;

  // Round constant for rounds 1..10; any other index yields zero.
  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // RotWord: cyclic left rotation of a word by one byte.
  function automatic logic [31:0] rot_word(input logic [31:0] x);
    return {x[23:0], x[31:24]};
  endfunction

endpackage

// File: rtl/aes_subword.sv
// aes_subword: AES SubWord, four parallel S-box lookups on a 32-bit word.
// Purely combinational; also usable as a slice of a SubBytes stage.
module aes_subword (
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign word_o = {SBOX[word_i[31:24]], SBOX[word_i[23:16]],
                   SBOX[word_i[15:8]],  SBOX[word_i[7:0]]};

endmodule

// File: rtl/aes_key_sched.sv
// aes_key_sched: iterative AES-128 key schedule. Takes one cipher key and
// streams rk0..rk10 (or rk10..rk0) computing one expansion step per cycle.
// Build option: define AES_KS_DECRYPT_EN to add decrypt order (dir=1),
// the PREP state and the inverse step; without it dir is ignored.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. key_ready/rk_valid are registered; once rk_valid is high the
// rk_* outputs hold until the transfer, and ready may toggle freely.
module aes_key_sched #(
  parameter int NR   = aes_ks_pkg::NR,
  parameter int RK_W = aes_ks_pkg::RK_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RK_W-1:0] key_in,
  input  logic            key_valid,
  output logic            key_ready,
  input  logic            dir,
  input  logic            flush,
  output logic [RK_W-1:0] rk_data,
  output logic [3:0]      rk_idx,
  output logic            rk_last,
  output logic            rk_valid,
  input  logic            rk_ready
);

  import aes_ks_pkg::*;

  localparam logic [3:0] LAST_IDX = 4'(NR);

  ks_state_e       state_q, state_d;
  logic [RK_W-1:0] rk_data_q, rk_data_d;
  logic [3:0]      rk_idx_q, rk_idx_d;
  logic            rk_last_q, rk_last_d;
  logic            rk_valid_q, rk_valid_d;
  logic            key_ready_q, key_ready_d;

  logic [31:0]     w0, w1, w2, w3;
  logic [31:0]     f0, f1, f2, f3;
  logic [31:0]     sub_in, sub_out, t_word;
  logic [3:0]      rc_idx;
  logic [RK_W-1:0] fwd_key;

  assign {w0, w1, w2, w3} = rk_data_q;

`ifdef AES_KS_DECRYPT_EN
  logic            dir_q, dir_d;
  logic            use_inv;
  logic [31:0]     p1, p2, p3;
  logic [RK_W-1:0] inv_key;

  // Undo the XOR chain first; p3 is the previous w3 and feeds SubWord.
  assign p3      = w3 ^ w2;
  assign p2      = w2 ^ w1;
  assign p1      = w1 ^ w0;
  assign use_inv = dir_q && (state_q == STREAM);
  assign sub_in  = use_inv ? p3 : w3;
  assign rc_idx  = use_inv ? rk_idx_q : rk_idx_q + 4'd1;
  assign inv_key = {w0 ^ t_word, p1, p2, p3};
`else
  logic unused_dir;
  assign unused_dir = dir;
  assign sub_in     = w3;
  assign rc_idx     = rk_idx_q + 4'd1;
`endif

  // Single S-box word shared by the forward and inverse steps.
  aes_subword u_subword (
    .word_i(rot_word(sub_in)),
    .word_o(sub_out)
  );

  assign t_word  = sub_out ^ {rcon(rc_idx), 24'h0};
  assign f0      = w0 ^ t_word;
  assign f1      = w1 ^ f0;
  assign f2      = w2 ^ f1;
  assign f3      = w3 ^ f2;
  assign fwd_key = {f0, f1, f2, f3};

  // State and output registers; reset drops any key in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rk_data_q   <= '0;
      rk_idx_q    <= '0;
      rk_last_q   <= 1'b0;
      rk_valid_q  <= 1'b0;
      key_ready_q <= 1'b1;
`ifdef AES_KS_DECRYPT_EN
      dir_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rk_data_q   <= rk_data_d;
      rk_idx_q    <= rk_idx_d;
      rk_last_q   <= rk_last_d;
      rk_valid_q  <= rk_valid_d;
      key_ready_q <= key_ready_d;
`ifdef AES_KS_DECRYPT_EN
      dir_q       <= dir_d;
`endif
    end
  end

  // Next state: key load, PREP walk to rk10, and the streaming step.
  always_comb begin
    state_d     = state_q;
    rk_data_d   = rk_data_q;
    rk_idx_d    = rk_idx_q;
    rk_last_d   = rk_last_q;
    rk_valid_d  = rk_valid_q;
    key_ready_d = key_ready_q;
`ifdef AES_KS_DECRYPT_EN
    dir_d       = dir_q;
`endif
    case (state_q)
      IDLE: begin
        if (key_valid && key_ready_q) begin
          rk_data_d   = key_in;
          rk_idx_d    = '0;
          rk_last_d   = 1'b0;
          key_ready_d = 1'b0;
`ifdef AES_KS_DECRYPT_EN
          dir_d = dir;
          if (dir) begin
            state_d    = PREP;
            rk_valid_d = 1'b0;
          end else begin
            state_d    = STREAM;
            rk_valid_d = 1'b1;
          end
`else
          state_d    = STREAM;
          rk_valid_d = 1'b1;
`endif
        end
      end
`ifdef AES_KS_DECRYPT_EN
      PREP: begin
        if (flush) begin
          state_d     = IDLE;
          rk_valid_d  = 1'b0;
          rk_last_d   = 1'b0;
          key_ready_d = 1'b1;
        end else begin
          rk_data_d = fwd_key;
          rk_idx_d  = rk_idx_q + 4'd1;
          if (rk_idx_q == LAST_IDX - 4'd1) begin
            state_d    = STREAM;
            rk_valid_d = 1'b1;
          end
        end
      end
`endif
      STREAM: begin
        if (flush) begin
          state_d     = IDLE;
          rk_valid_d  = 1'b0;
          rk_last_d   = 1'b0;
          key_ready_d = 1'b1;
        end else if (rk_valid_q && rk_ready) begin
          if (rk_last_q) begin
            state_d     = IDLE;
            rk_valid_d  = 1'b0;
            rk_last_d   = 1'b0;
            key_ready_d = 1'b1;
`ifdef AES_KS_DECRYPT_EN
          end else if (dir_q) begin
            rk_data_d = inv_key;
            rk_idx_d  = rk_idx_q - 4'd1;
            rk_last_d = (rk_idx_q == 4'd1);
`endif
          end else begin
            rk_data_d = fwd_key;
            rk_idx_d  = rk_idx_q + 4'd1;
            rk_last_d = ((rk_idx_q + 4'd1) == LAST_IDX);
          end
        end
      end
      default: begin
        state_d     = IDLE;
        rk_valid_d  = 1'b0;
        rk_last_d   = 1'b0;
        key_ready_d = 1'b1;
      end
    endcase
  end

  assign key_ready = key_ready_q;
  assign rk_data   = rk_data_q;
  assign rk_idx    = rk_idx_q;
  assign rk_last   = rk_last_q;
  assign rk_valid  = rk_valid_q;

endmodule

// File: tb/tb_aes_key_sched.sv
// tb_aes_key_sched: directed bench for aes_key_sched with a FIPS-197 level
// key-expansion model (S-box derived from GF(2^8) inverse + affine map).
module tb_aes_key_sched;

  localparam int W = 133;  // {last, idx[3:0], data[127:0]}
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk, rst;
  logic [127:0] key_in;
  logic         key_valid, key_ready, dir, flush;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         rk_last, rk_valid, rk_ready;

  aes_key_sched dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .dir(dir), .flush(flush), .rk_data(rk_data),
    .rk_idx(rk_idx), .rk_last(rk_last), .rk_valid(rk_valid), .rk_ready(rk_ready)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual running required done");
    $fatal(1);
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   sbox_m [256];
  logic [127:0] rk_m   [11];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic void build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [31:0] sub_w(input logic [31:0] x);
    return {sbox_m[x[31:24]], sbox_m[x[23:16]], sbox_m[x[15:8]], sbox_m[x[7:0]]};
  endfunction

  // Textbook 44-word expansion.
  function automatic void expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic push_stream(input logic [127:0] k, input logic d);
    logic dec = d;
`ifndef AES_KS_DECRYPT_EN
    dec = 1'b0;
`endif
    expand(k);
    if (dec) for (int r = 10; r >= 0; r--) exp_q.push_back({r == 0, 4'(r), rk_m[r]});
    else     for (int r = 0; r <= 10; r++) exp_q.push_back({r == 10, 4'(r), rk_m[r]});
  endtask

  // ---------------- compare process ----------------
  logic         stall_prev  = 1'b0;
  logic         expect_idle = 1'b0;
  logic [W-1:0] held        = '0;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev  = 1'b0;
      expect_idle = 1'b0;
    end else begin
      if (expect_idle) begin
        check("idle_rk_valid", W'(rk_valid), W'(1'b0));
        check("idle_key_ready", W'(key_ready), W'(1'b1));
      end
      expect_idle = 1'b0;
      if (stall_prev) begin
        check("stall_valid", W'(rk_valid), W'(1'b1));
        check("stall_hold", {rk_last, rk_idx, rk_data}, held);
      end
      if (rk_valid && key_ready) check("ready_exclusive", W'({rk_valid, key_ready}), W'(2'b10));
      if (rk_valid && rk_ready && !flush) begin
        check("rk_expected", W'(exp_q.size() != 0), W'(1'b1));
        if (exp_q.size() != 0) begin
          check("rk_key", {rk_last, rk_idx, rk_data}, exp_q[0]);
          void'(exp_q.pop_front());
        end
        if (rk_last) expect_idle = 1'b1;
      end
      if (flush && (rk_valid || !key_ready)) expect_idle = 1'b1;
      stall_prev = rk_valid && !rk_ready && !flush;
      held       = {rk_last, rk_idx, rk_data};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_key(input logic [127:0] k, input logic d);
    int n = 0;
    key_in = k; dir = d; key_valid = 1'b1;
    while (!key_ready && n < 100) begin tick(); n++; end
    check("key_ready_seen", W'(key_ready), W'(1'b1));
    tick();
    key_valid = 1'b0;
  endtask

  task automatic drain(input bit rand_ready);
    int n = 0;
    while ((exp_q.size() != 0 || !key_ready) && n < 400) begin
      rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    check("drain_done", W'({exp_q.size() == 0, key_ready}), W'(2'b11));
    rk_ready = 1'b1;
  endtask

  task automatic wait_idx(input logic [3:0] idx);
    int n = 0;
    while (!(rk_valid && rk_idx == idx) && n < 50) begin tick(); n++; end
    check("reach_idx", W'({rk_valid, rk_idx}), W'({1'b1, idx}));
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    rst = 1'b1; key_in = '0; key_valid = 1'b0; dir = 1'b0; flush = 1'b0; rk_ready = 1'b1;

    build_sbox();
    check("model_sbox_00", W'(sbox_m[8'h00]), W'(8'h63));
    check("model_sbox_53", W'(sbox_m[8'h53]), W'(8'hed));
    expand(K1);
    check("model_k1_rk1", W'(rk_m[1]), W'(128'ha0fafe1788542cb123a339392a6c7605));
    check("model_k1_rk10", W'(rk_m[10]), W'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
    expand(K2);
    check("model_k2_rk10", W'(rk_m[10]), W'(128'h13111d7fe3944a17f307a78b4d2b30c5));

    repeat (2) tick();
    check("rst_key_ready", W'(key_ready), W'(1'b1));
    check("rst_rk_valid", W'(rk_valid), W'(1'b0));
    check("rst_rk_last", W'(rk_last), W'(1'b0));
    check("rst_rk_data", W'(rk_data), W'(128'h0));
    check("rst_rk_idx", W'(rk_idx), W'(4'h0));
    #2 rst = 1'b0;
    tick();

    // Encrypt, no backpressure: rk0 one cycle after the key handshake.
    push_stream(K1, 1'b0);
    send_key(K1, 1'b0);
    check("enc_rk0_valid", W'(rk_valid), W'(1'b1));
    check("enc_rk0_idx", W'(rk_idx), W'(4'd0));
    check("enc_rk0_data", W'(rk_data), W'(K1));
    drain(1'b0);

    // Encrypt with random backpressure, starting stalled.
    rk_ready = 1'b0;
    push_stream(K1, 1'b0);
    send_key(K1, 1'b0);
    drain(1'b1);

    // Decrypt order (dir ignored when the feature is not built).
    push_stream(K1, 1'b1);
    send_key(K1, 1'b1);
`ifdef AES_KS_DECRYPT_EN
    for (int c = 1; c <= 10; c++) begin
      check("prep_valid_low", W'(rk_valid), W'(1'b0));
      tick();
    end
    check("dec_rk10_valid", W'(rk_valid), W'(1'b1));
    check("dec_rk10_idx", W'(rk_idx), W'(4'd10));
    check("dec_rk10_data", W'(rk_data), W'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
`else
    check("dir_ignored_valid", W'(rk_valid), W'(1'b1));
    check("dir_ignored_idx", W'(rk_idx), W'(4'd0));
`endif
    drain(1'b0);

    // Flush while rk4 is being handed over, then a clean restart.
    push_stream(K1, 1'b0);
    send_key(K1, 1'b0);
    wait_idx(4'd4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_rk_valid", W'(rk_valid), W'(1'b0));
    check("flush_key_ready", W'(key_ready), W'(1'b1));
    check("flush_rk_last", W'(rk_last), W'(1'b0));
    exp_q.delete();
    push_stream(K2, 1'b0);
    send_key(K2, 1'b0);
    check("restart_rk0_idx", W'(rk_idx), W'(4'd0));
    check("restart_rk0_data", W'(rk_data), W'(K2));
    drain(1'b0);

    // Asynchronous reset in the middle of rk6.
    push_stream(K1, 1'b0);
    send_key(K1, 1'b0);
    wait_idx(4'd6);
    #1 rst = 1'b1;
    #1;
    check("arst_key_ready", W'(key_ready), W'(1'b1));
    check("arst_rk_valid", W'(rk_valid), W'(1'b0));
    check("arst_rk_last", W'(rk_last), W'(1'b0));
    check("arst_rk_data", W'(rk_data), W'(128'h0));
    check("arst_rk_idx", W'(rk_idx), W'(4'h0));
    exp_q.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    push_stream(K2, 1'b0);
    send_key(K2, 1'b0);
    drain(1'b1);

    // key_valid held through a stream: second key only taken once idle.
    push_stream(K1, 1'b0);
    push_stream(K2, 1'b0);
    key_in = K1; dir = 1'b0; key_valid = 1'b1;
    n = 0;
    while (!key_ready && n < 100) begin tick(); n++; end
    tick();
    key_in = K2;
    n = 0;
    while (!key_ready && n < 100) begin tick(); n++; end
    check("held_valid_wait", W'(n), W'(11));
    tick();
    key_valid = 1'b0;
    drain(1'b0);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
